// File: rtl/score_timer_bcd.sv
// Score / countdown / round counter for a reaction game, all values kept in BCD.
// Rising edges of start, pause and hit drive a four-state round controller.
// A prescaler turns clk into 1-second ticks.
module score_timer_bcd #(
   parameter int unsigned TICK_DIV  = 100000000,
   parameter logic [7:0]  GAME_TIME = 8'h60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       pause,
   input  logic       hit,
   output logic [3:0] num0,
   output logic [3:0] num1,
   output logic [3:0] num2,
   output logic [3:0] num3,
   output logic [3:0] num4,
   output logic [3:0] num5,
   output logic [3:0] num6,
   output logic [3:0] num7,
   output logic [1:0] state,
   output logic       over_pulse
);

   localparam int unsigned PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_RUN   = 2'b01;
   localparam logic [1:0] S_PAUSE = 2'b10;
   localparam logic [1:0] S_OVER  = 2'b11;

   logic [1:0]    state_q, state_d;
   logic          start_prev_q, start_prev_d;
   logic          pause_prev_q, pause_prev_d;
   logic          hit_prev_q, hit_prev_d;
   logic [15:0]   score_q, score_d;
   logic [7:0]    time_q, time_d;
   logic [7:0]    rounds_q, rounds_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          over_pulse_q, over_pulse_d;

   logic start_e, pause_e, hit_e;
   logic tick, final_tick;

   // BCD increment of a packed group of digits; all-nines wraps to zero
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // BCD decrement of two digits; never called with 00
   function automatic logic [7:0] bcd_dec2(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] == 4'd0) begin
         r = {v[7:4] - 4'd1, 4'd9};
      end else begin
         r = {v[7:4], v[3:0] - 4'd1};
      end
      return r;
   endfunction

   // Rising-edge detect against the previous sample
   assign start_e    = start & ~start_prev_q;
   assign pause_e    = pause & ~pause_prev_q;
   assign hit_e      = hit & ~hit_prev_q;
   assign tick       = (state_q == S_RUN) && (presc_q == PRESC_MAX);
   assign final_tick = tick && (time_q == 8'h01);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; end of round takes priority over a pause request
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_OVER: if (start_e) state_d = S_RUN;
         S_RUN: begin
            if (final_tick) begin
               state_d = S_OVER;
            end else if (pause_e) begin
               state_d = S_PAUSE;
            end
         end
         S_PAUSE: if (pause_e) state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values, decided on the pre-edge state
   always_comb begin
      start_prev_d = start;
      pause_prev_d = pause;
      hit_prev_d   = hit;
      score_d      = score_q;
      time_d       = time_q;
      rounds_d     = rounds_q;
      presc_d      = presc_q;
      over_pulse_d = (state_q == S_RUN) && (state_d == S_OVER);
      case (state_q)
         S_IDLE, S_OVER: begin
            if (start_e) begin
               score_d  = 16'h0000;
               time_d   = GAME_TIME;
               presc_d  = '0;
               rounds_d = 8'(bcd_inc({8'h00, rounds_q}));
            end
         end
         S_RUN: begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) time_d = bcd_dec2(time_q);
            if (hit_e && (score_q != 16'h9999)) score_d = bcd_inc(score_q);
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         start_prev_q <= 1'b0;
         pause_prev_q <= 1'b0;
         hit_prev_q   <= 1'b0;
         score_q      <= 16'h0000;
         time_q       <= GAME_TIME;
         rounds_q     <= 8'h00;
         presc_q      <= '0;
         over_pulse_q <= 1'b0;
      end else begin
         start_prev_q <= start_prev_d;
         pause_prev_q <= pause_prev_d;
         hit_prev_q   <= hit_prev_d;
         score_q      <= score_d;
         time_q       <= time_d;
         rounds_q     <= rounds_d;
         presc_q      <= presc_d;
         over_pulse_q <= over_pulse_d;
      end
   end

   assign num0       = score_q[3:0];
   assign num1       = score_q[7:4];
   assign num2       = score_q[11:8];
   assign num3       = score_q[15:12];
   assign num4       = time_q[3:0];
   assign num5       = time_q[7:4];
   assign num6       = rounds_q[3:0];
   assign num7       = rounds_q[7:4];
   assign state      = state_q;
   assign over_pulse = over_pulse_q;

endmodule
